// File: rtl/module_display_scan_if.sv
// Bundles the load/value/blanking controls and the scan outputs of the
// display scanner so the parent hooks it up with a single connection.
interface module_display_scan_if #(
    parameter int unsigned N_DIGITS = 4
);
    localparam int unsigned IdxW = $clog2(N_DIGITS);

    logic                  load_i;
    logic [4*N_DIGITS-1:0] value_i;
    logic                  blank_lz_i;
    logic [3:0]            digit_o;
    logic [N_DIGITS-1:0]   an_o;
    logic [IdxW-1:0]       idx_o;
    logic                  pending_o;
    logic                  frame_o;

    // Side that supplies values and consumes the scan outputs
    modport master (
        output load_i,
        output value_i,
        output blank_lz_i,
        input  digit_o,
        input  an_o,
        input  idx_o,
        input  pending_o,
        input  frame_o
    );

    // The scanner itself
    modport slave (
        input  load_i,
        input  value_i,
        input  blank_lz_i,
        output digit_o,
        output an_o,
        output idx_o,
        output pending_o,
        output frame_o
    );
endinterface

// File: rtl/module_display_scan.sv
// Time-multiplexed scanner for an N-digit common-anode 7-segment display.
// A loaded BCD value waits in a shadow register and is only copied into the
// displayed value at a frame boundary, so a frame never mixes two values.
module module_display_scan #(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned REFRESH_DIV = 27000,
    parameter int unsigned BLANK_CYC   = 2
) (
    input logic                  clk,
    input logic                  rst,
    module_display_scan_if.slave bus
);
    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IdxW = $clog2(N_DIGITS);
    localparam int unsigned ValW = 4 * N_DIGITS;

    localparam logic [CntW-1:0]     CntLast = CntW'(REFRESH_DIV - 1);
    localparam logic [IdxW-1:0]     IdxLast = IdxW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AnOne   = N_DIGITS'(1);

    // Scan state
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0] idx_q, idx_d;

    // Value pipeline: shadow holds the latest load, disp is what is shown
    logic [ValW-1:0] shadow_q, shadow_d;
    logic [ValW-1:0] disp_q, disp_d;
    logic            pending_q, pending_d;

    // Registered outputs
    logic [3:0]          digit_q, digit_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [IdxW-1:0]     idx_out_q;
    logic                pending_out_q;

    logic            wrap;
    logic            boundary;
    logic            in_blank;
    logic            lz_blanked;
    logic [3:0]      cur_digit;
    logic [IdxW-1:0] msd;

    assign wrap     = (cnt_q == CntLast);
    assign boundary = wrap && (idx_q == IdxLast);

    // Anti-ghosting window at the start of every slot
    if (BLANK_CYC == 0) begin : g_no_blank
        assign in_blank = 1'b0;
    end else begin : g_blank
        assign in_blank = (cnt_q < CntW'(BLANK_CYC));
    end

    // Prescaler and slot index advance
    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        idx_d = idx_q;
        if (wrap) begin
            cnt_d = '0;
            idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
        end
    end

    // Load capture and frame-boundary commit; a load on the boundary bypasses shadow
    always_comb begin
        shadow_d  = shadow_q;
        disp_d    = disp_q;
        pending_d = pending_q;
        if (bus.load_i && boundary) begin
            shadow_d  = bus.value_i;
            disp_d    = bus.value_i;
            pending_d = 1'b0;
        end else if (bus.load_i) begin
            shadow_d  = bus.value_i;
            pending_d = 1'b1;
        end else if (boundary && pending_q) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
        end
    end

    // Digit under scan and most significant nonzero digit of the displayed value
    always_comb begin
        cur_digit = 4'd0;
        msd       = '0;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            if (idx_q == IdxW'(k)) begin
                cur_digit = disp_q[4*k +: 4];
            end
            if (disp_q[4*k +: 4] != 4'd0) begin
                msd = IdxW'(k);
            end
        end
    end

    // Digit 0 can never be blanked since idx > msd is impossible when idx is 0
    assign lz_blanked = bus.blank_lz_i && (idx_q > msd);

    // Next values of the registered outputs
    always_comb begin
        digit_d = cur_digit;
        an_d    = '1;
        if (!in_blank && !lz_blanked) begin
            an_d = ~(AnOne << idx_q);
        end
    end

    // All state and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            shadow_q      <= '0;
            disp_q        <= '0;
            pending_q     <= 1'b0;
            digit_q       <= 4'd0;
            an_q          <= '1;
            idx_out_q     <= '0;
            pending_out_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            disp_q        <= disp_d;
            pending_q     <= pending_d;
            digit_q       <= digit_d;
            an_q          <= an_d;
            idx_out_q     <= idx_q;
            pending_out_q <= pending_q;
        end
    end

    assign bus.digit_o   = digit_q;
    assign bus.an_o      = an_q;
    assign bus.idx_o     = idx_out_q;
    assign bus.pending_o = pending_out_q;
    // Combinational so it coincides with the cycle whose edge commits the new frame
    assign bus.frame_o   = boundary;

    // Never more than one anode enabled
    a_an_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(~an_q));

endmodule

// File: doc/module_display_scan.md
Name: module_display_scan

Overview:
- Time-multiplexed scanner for an N-digit common-anode 7-segment display.
- Latches a packed BCD value, cycles through the digits at a fixed refresh rate, and presents one 4-bit digit per slot to the downstream BCD-to-segment decoder.
- Drives the active-low anode enables that match the digit being presented.
- Tear-free updates: a new value takes effect only at a frame boundary. Optional leading-zero blanking.

Parameters:
- N_DIGITS, 4: number of display digits; range 2..8.
- REFRESH_DIV, 27000: clock cycles per digit slot; must be ≥ BLANK_CYC+2.
- BLANK_CYC, 2: cycles at the start of each slot with all anodes off (anti-ghosting).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- load_i  in  1  one-cycle strobe; capture value_i
- value_i  in  4*N_DIGITS  packed BCD; digit k = value_i[4k+3:4k]; digit 0 = least significant
- blank_lz_i  in  1  1 = suppress leading zeros
- digit_o  out  4  nibble for the decoder's w input
- an_o  out  N_DIGITS  anode enables, active low, one-hot-low or all ones
- idx_o  out  $clog2(N_DIGITS)  index of the slot being scanned
- pending_o  out  1  a loaded value is waiting for the frame boundary
- frame_o  out  1  one-cycle pulse at every frame boundary

Behaviour:
- Reset: all state is cleared synchronously on the rising clk edge with rst=1, and the registered outputs follow on the same edge. rst overrides every other input, including mid-slot and mid-frame; the pending load is discarded.
  - cnt=0, idx=0, shadow=0, disp=0, pending=0.
  - digit_o=0, an_o=all ones, idx_o=0, pending_o=0, frame_o=0.
- Prescaler: cnt counts 0..REFRESH_DIV-1 and wraps to 0.
- Slot advance: on the wrap edge, idx advances mod N_DIGITS (N_DIGITS-1 → 0).
- Frame boundary: the wrap edge with idx==N_DIGITS-1.
- Load:
  - load_i=1 captures value_i into shadow and sets pending.
  - A repeated load before the boundary overwrites shadow; last value wins.
- Commit: at a frame boundary with pending=1, disp<=shadow and pending<=0.
- Load and boundary in the same cycle: value_i is committed directly to disp and pending<=0 (bypass; the newest value wins).
- frame_o is asserted on the boundary cycle (cnt==REFRESH_DIV-1, idx==N_DIGITS-1), whether or not a commit occurs.
- Leading-zero blanking, evaluated on disp:
  - msd = highest k with digit k ≠ 0; msd = 0 if all digits are zero.
  - Digit k is blanked when blank_lz_i=1 and k>msd. Digit 0 is never blanked.
  - Nonzero digits > 9 count as nonzero and pass through unmodified (the decoder handles 0xA–0xF).
- Output registers (1-cycle latency from internal state):
  - digit_o <= disp digit[idx].
  - idx_o <= idx.
  - an_o <= all ones if cnt<BLANK_CYC or digit idx is blanked; otherwise ~(1<<idx).
  - pending_o <= pending.
- Invariants:
  - At most one bit of an_o is ever low.
  - digit_o is stable throughout any cycle in which an_o is not all ones.
- blank_lz_i is sampled every cycle; a change takes effect in the next registered an_o.

Test Plan:
(Sim parameters unless stated: N_DIGITS=4, REFRESH_DIV=4, BLANK_CYC=1.)
- Reset check: rst high for 3 cycles then low → an_o=4'b1111, digit_o=0, pending_o=0 during reset. After release, an_o goes 1111,1110,1110,1110 for slot 0. An all-zero display with blanking off shows 0 on every digit.
- Basic scan: load value_i=16'h1234 mid-frame, blank_lz_i=0 → pending_o=1 until the boundary. After that, per slot: (digit_o, an_o) = (4,1110), (3,1101), (2,1011), (1,0111), with an_o=1111 on the first cycle of each slot. frame_o pulses once every 16 cycles.
- Tear-free update: load 16'h1234, then 16'h5678 two cycles later, both before the boundary → 1234 is never displayed; the first full frame shows 8,7,6,5. pending_o clears on the boundary edge.
- Bypass: load_i coincides exactly with the boundary cycle (value 16'h0042) → the next frame shows 2,4,…; pending_o stays 0.
- Leading-zero blanking: disp=16'h0042 with blank_lz_i=1 → slots 2 and 3 keep an_o=1111 for their full duration. disp=16'h0000 → only digit 0 lights, digit_o=0. disp=16'h0A05 → digits 0,1,2 lit, digit_o=A in slot 2.
- Reset mid-operation: assert rst during slot 2 with pending=1 → next cycle an_o=1111 and idx_o=0. After release, the display shows zeros and pending_o=0; the pending load is lost.
